// File: rtl/demux_1to2_8bits_buf.sv
// Buffered 1-to-2 byte demultiplexer: one producer steers bytes into two
// independent FIFOs, each draining to its own consumer with a delivery counter.
module demux_1to2_8bits_buf #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out0_data,
  output logic       out0_valid,
  input  logic       out0_ready,
  output logic [7:0] out1_data,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [7:0] count0,
  output logic [7:0] count1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [1:0] w_full;
  logic [1:0] w_valid;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_consReady;
  logic       w_accept;
  logic [7:0] w_head  [2];
  logic [7:0] w_count [2];

  // Readiness looks only at the addressed FIFO; a pop on the same edge does
  // not open a slot until the following cycle, so there is no bypass path.
  assign in_ready    = ~rst & ~(in_sel ? w_full[1] : w_full[0]);
  assign w_accept    = in_valid & in_ready;
  assign w_push[0]   = w_accept & ~in_sel;
  assign w_push[1]   = w_accept & in_sel;
  assign w_consReady = {out1_ready, out0_ready};
  assign w_pop       = w_valid & w_consReady;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [OCC_W-1:0] r_occ;
    logic [7:0]       r_count;

    assign w_full[g]  = (r_occ == OCC_W'(DEPTH));
    assign w_valid[g] = (r_occ != '0);
    assign w_head[g]  = w_valid[g] ? r_mem[r_rdPtr] : 8'h00;
    assign w_count[g] = r_count;

    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_mem[r_wrPtr] <= in_data;
      end
    end

    // Pointers wrap naturally because DEPTH is a power of two; occupancy is
    // what tells full from empty when the pointers coincide.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_occ   <= '0;
        r_count <= 8'h00;
      end else begin
        if (w_push[g]) begin
          r_wrPtr <= r_wrPtr + PTR_W'(1);
        end
        if (w_pop[g]) begin
          r_rdPtr <= r_rdPtr + PTR_W'(1);
          r_count <= r_count + 8'd1;
        end
        case ({w_push[g], w_pop[g]})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign count0     = w_count[0];
  assign count1     = w_count[1];

endmodule
